aileron_seq: RTL and testbench
==============================

# aileron_seq

Parametrised, clocked successor to the combinational aileron valve decoder. Maps a signed angle command to a thermometer-coded number of open valve stages on the left (negative angle) or right (positive angle) side. Moves at most one stage per `STEP_CYC` cycles, so valve slew is rate-limited. Never opens valves on both sides at once. Sits between the flight-command register and the valve drivers.

## Interface

Parameters:
- `ANG_W`, 4, width of the signed angle command (≥2)
- `STAGES`, 2, valves per side (≥1)
- `ANG_STEP`, 3, angle magnitude units per additional stage (≥1)
- `STEP_CYC`, 4, minimum cycles between consecutive stage changes (≥1)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ang`  in  ANG_W  signed angle command, two's complement
- `ang_valid`  in  1  `ang` is sampled on an edge where this is high
- `center`  in  1  neutral request; forces target to 0, has priority over `ang_valid`
- `valves_l`  out  STAGES  left valves, bit i = stage i+1 open
- `valves_r`  out  STAGES  right valves, bit i = stage i+1 open
- `busy`  out  1  position ≠ target
- `at_target`  out  1  equals `~busy`

## Operation

- **Internal state:**
  - `tgt`, signed position in [-STAGES, +STAGES].
  - `pos`, signed position in the same range.
  - `cnt`, dwell counter 0..STEP_CYC-1.
- **Target computation:** m = |ang|, computed at ANG_W+1 bits, so the most-negative `ang` is handled without overflow.
  - lvl = 0 if m==0.
  - Otherwise lvl = min(STAGES, 1 + (m-1)/ANG_STEP), using integer division.
  - tgt = -lvl for ang<0, +lvl for ang>0.
  - With defaults: |ang| 1..3 → 1 stage; |ang| 4..8 → 2 stages.
- **Target update each edge:**
  - If `center`, tgt ← 0.
  - Else if `ang_valid`, tgt ← the computed target.
  - Else tgt holds.
  - A new command may arrive at any time, including mid-move; it retargets without restarting the dwell.
- **Motion each edge** (uses the registered `tgt`):
  - If pos≠tgt and cnt==0: pos steps by ±1 toward tgt, and cnt ← STEP_CYC-1.
  - Else if cnt≠0: cnt decrements.
- **Side crossing:** a move from negative to positive, or the reverse, passes through pos=0, where all valves are closed.
- **Outputs (registered-state decode):**
  - valves_l[i] = (pos ≤ -(i+1)).
  - valves_r[i] = (pos ≥ i+1).
  - `valves_l` and `valves_r` are never both nonzero.
  - Neutral (pos=0) drives all valves to 0. Outputs are never X.
- **Reset values:** tgt=0, pos=0, cnt=0.
  - All valves 0, `busy`=0, `at_target`=1.
  - Reset mid-move abandons the move; everything is closed after the reset edge.
- **States:**
  - IDLE: pos==tgt.
  - MOVE: pos≠tgt and cnt==0; step taken this edge.
  - DWELL: cnt≠0.
  - IDLE→MOVE or DWELL when tgt changes. DWELL→MOVE when cnt reaches 0 and pos≠tgt. MOVE→DWELL (STEP_CYC>1) or MOVE→MOVE (STEP_CYC=1).

## Timing

- Command at edge E (tgt registered). If idle long enough for cnt==0, the first stage change is visible after edge E+1.
- Subsequent stage changes occur every STEP_CYC edges.
- Full swing from -STAGES to +STAGES takes 2·STAGES steps: 1 + (2·STAGES-1)·STEP_CYC edges after the command.
- A command arriving during DWELL waits for the remaining dwell.
- A command equal to the current pos produces no motion and no dwell.

## Test plan

- **Reset:**
  - Stimulus: hold `rst` 2 edges with `ang`=5 and `ang_valid`=1.
  - Required: `valves_l`=`valves_r`=00, `busy`=0, `at_target`=1.
- **Full deflection left:**
  - Stimulus: `ang`=-8, valid at edge 0.
  - Required: `valves_l`=01 after edge 1 and 11 after edge 5; `busy` falls after edge 5; `valves_r`=00 throughout.
- **Angle sweep:**
  - Stimulus: settle each `ang` from -8 to +7.
  - Required: -8..-4→l=11, -3..-1→l=01, 0→all 00, 1..3→r=01, 4..7→r=11.
- **Side crossing:**
  - Stimulus: from pos=-2, command `ang`=+2.
  - Required: l=11→01→00, then r=01, at 4-edge spacing; no edge has l≠0 and r≠0.
- **Retarget and priority:**
  - Stimulus: from pos=0, command +7; after the first step, assert `ang`=-1 with `ang_valid` and `center` in the same edge.
  - Required: tgt=0; pos returns to 0 at the 4-edge dwell boundary.
- **Reset mid-move and STEP_CYC=1 variant:**
  - Stimulus: assert `rst` during DWELL.
  - Required: all valves 0 after that edge.
  - Stimulus: with STEP_CYC=1, command -8→+7.
  - Required: pos changes on every edge, reaching +2 in 4 edges.

Source files
------------

// File: rtl/aileron_if.sv
// aileron_if: command/valve bundle between the flight-command register and
// the aileron valve sequencer.
//   ang        signed angle command (two's complement, ANG_W bits)
//   ang_valid  ang is sampled on a rising edge where this is high
//   center     neutral request, overrides ang_valid
//   valves_l   left valves, thermometer coded, bit i = stage i+1 open
//   valves_r   right valves, thermometer coded, bit i = stage i+1 open
//   busy       position has not reached the target yet
//   at_target  ~busy
// master: command source.  slave: sequencer.
interface aileron_if #(
   parameter int ANG_W  = 4,
   parameter int STAGES = 2
);
   logic signed [ANG_W-1:0]  ang;
   logic                     ang_valid;
   logic                     center;
   logic        [STAGES-1:0] valves_l;
   logic        [STAGES-1:0] valves_r;
   logic                     busy;
   logic                     at_target;

   modport master (
      output ang, ang_valid, center,
      input  valves_l, valves_r, busy, at_target
   );

   modport slave (
      input  ang, ang_valid, center,
      output valves_l, valves_r, busy, at_target
   );
endinterface

// File: rtl/aileron_seq.sv
// aileron_seq: rate-limited aileron valve sequencer.
// Maps a signed angle command onto a signed stage position; negative opens
// left valves, positive opens right valves, thermometer coded. The position
// moves one stage at a time with at least STEP_CYC cycles between moves,
// and always passes through neutral (all closed) when changing side.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  aileron_if.slave (ang, ang_valid, center in; valves_l, valves_r,
//        busy, at_target out)
module aileron_seq #(
   parameter int ANG_W    = 4,
   parameter int STAGES   = 2,
   parameter int ANG_STEP = 3,
   parameter int STEP_CYC = 4
) (
   input  logic      clk,
   input  logic      rst,
   aileron_if.slave  bus
);

   // Signed position width covering -STAGES..+STAGES.
   localparam int PW = $clog2(STAGES + 1) + 1;
   localparam int CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
   localparam logic signed [PW-1:0] ONE      = PW'(1);
   localparam logic        [CW-1:0] DWELL_LD = CW'(STEP_CYC - 1);

   // IDLE: pos==tgt. MOVE: step is taken on the coming edge.
   // DWELL: waiting out the slew interval.
   typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_t;

   state_t               st, st_d;
   logic signed [PW-1:0] tgt, tgt_d, pos, pos_d;
   logic        [CW-1:0] cnt, cnt_d;

   // ---------------- command -> target stage ----------------
   logic signed [ANG_W:0] ax;
   logic        [ANG_W:0] mag;
   logic        [31:0]    m32, lvl32;
   logic signed [PW-1:0]  lvl, cmd_tgt;

   always_comb begin
      // One extra bit so |most-negative| does not overflow.
      ax    = {bus.ang[ANG_W-1], bus.ang};
      mag   = ax[ANG_W] ? unsigned'(-ax) : unsigned'(ax);
      m32   = 32'(mag);
      lvl32 = '0;
      if (m32 != '0)
         lvl32 = (m32 - 32'd1) / 32'(ANG_STEP) + 32'd1;
      if (lvl32 > 32'(STAGES))
         lvl32 = 32'(STAGES);
      lvl     = PW'(lvl32);
      cmd_tgt = ax[ANG_W] ? -lvl : lvl;
   end

   // ---------------- next state ----------------
   always_comb begin
      tgt_d = tgt;
      pos_d = pos;
      cnt_d = cnt;
      st_d  = st;

      if (bus.center)
         tgt_d = '0;
      else if (bus.ang_valid)
         tgt_d = cmd_tgt;

      // Motion follows the registered target; a retarget arriving now only
      // takes effect from the next edge and never restarts the dwell.
      case (st)
         MOVE: begin
            pos_d = (pos < tgt) ? pos + ONE : pos - ONE;
            cnt_d = DWELL_LD;
         end
         DWELL:   cnt_d = cnt - CW'(1);
         default: ;
      endcase

      if (cnt_d != '0)
         st_d = DWELL;
      else if (pos_d != tgt_d)
         st_d = MOVE;
      else
         st_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st  <= IDLE;
         tgt <= '0;
         pos <= '0;
         cnt <= '0;
      end else begin
         st  <= st_d;
         tgt <= tgt_d;
         pos <= pos_d;
         cnt <= cnt_d;
      end
   end

   // ---------------- valve decode ----------------
   // Sign of pos selects the side, so both sides can never be open together.
   logic [STAGES-1:0] vl, vr;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      localparam logic signed [PW-1:0] K = PW'(i + 1);
      assign vl[i] = (pos <= -K);
      assign vr[i] = (pos >= K);
   end

   assign bus.valves_l  = vl;
   assign bus.valves_r  = vr;
   assign bus.busy      = (pos != tgt);
   assign bus.at_target = (pos == tgt);

endmodule

// File: tb/tb_aileron_seq.sv
// tb_aileron_seq: directed bench for aileron_seq. dut0 uses default
// parameters, dut1 uses STEP_CYC=1. Inputs change and outputs are sampled
// 1 time unit after the rising edge.
module tb_aileron_seq;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   aileron_if #(.ANG_W(4), .STAGES(2)) b0 ();
   aileron_if #(.ANG_W(4), .STAGES(2)) b1 ();

   aileron_seq #(.ANG_W(4), .STAGES(2), .ANG_STEP(3), .STEP_CYC(4))
      dut0 (.clk(clk), .rst(rst), .bus(b0));
   aileron_seq #(.ANG_W(4), .STAGES(2), .ANG_STEP(3), .STEP_CYC(1))
      dut1 (.clk(clk), .rst(rst), .bus(b1));

   typedef struct {
      logic signed [3:0] ang;
      logic        [1:0] l;
      logic        [1:0] r;
   } vec_t;

   vec_t tbl[16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present a command on dut0 for exactly one edge.
   task automatic cmd0(input logic signed [3:0] a, input logic c);
      b0.ang = a; b0.ang_valid = 1'b1; b0.center = c;
      tick();
      b0.ang_valid = 1'b0; b0.center = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{-4'sd8, 2'b11, 2'b00};
      tbl[1]  = '{-4'sd7, 2'b11, 2'b00};
      tbl[2]  = '{-4'sd6, 2'b11, 2'b00};
      tbl[3]  = '{-4'sd5, 2'b11, 2'b00};
      tbl[4]  = '{-4'sd4, 2'b11, 2'b00};
      tbl[5]  = '{-4'sd3, 2'b01, 2'b00};
      tbl[6]  = '{-4'sd2, 2'b01, 2'b00};
      tbl[7]  = '{-4'sd1, 2'b01, 2'b00};
      tbl[8]  = '{ 4'sd0, 2'b00, 2'b00};
      tbl[9]  = '{ 4'sd1, 2'b00, 2'b01};
      tbl[10] = '{ 4'sd2, 2'b00, 2'b01};
      tbl[11] = '{ 4'sd3, 2'b00, 2'b01};
      tbl[12] = '{ 4'sd4, 2'b00, 2'b11};
      tbl[13] = '{ 4'sd5, 2'b00, 2'b11};
      tbl[14] = '{ 4'sd6, 2'b00, 2'b11};
      tbl[15] = '{ 4'sd7, 2'b00, 2'b11};

      // ---- reset with a command pending ----
      rst = 1'b1;
      b0.ang = 4'sd5; b0.ang_valid = 1'b1; b0.center = 1'b0;
      b1.ang = 4'sd5; b1.ang_valid = 1'b1; b1.center = 1'b0;
      ticks(2);
      chk("rst_l", 32'(b0.valves_l), 32'h0);
      chk("rst_r", 32'(b0.valves_r), 32'h0);
      chk("rst_busy", 32'(b0.busy), 32'h0);
      chk("rst_at_target", 32'(b0.at_target), 32'h1);
      rst = 1'b0;
      b0.ang_valid = 1'b0;
      b1.ang_valid = 1'b0;
      tick();

      // ---- full deflection left ----
      cmd0(-4'sd8, 1'b0);                           // edge 0
      chk("defl_busy_e0", 32'(b0.busy), 32'h1);
      chk("defl_l_e0", 32'(b0.valves_l), 32'h0);
      for (int e = 1; e <= 5; e++) begin
         tick();
         chk("defl_l", 32'(b0.valves_l), (e < 5) ? 32'h1 : 32'h3);
         chk("defl_r", 32'(b0.valves_r), 32'h0);
         chk("defl_busy", 32'(b0.busy), (e < 5) ? 32'h1 : 32'h0);
      end
      chk("defl_at_target", 32'(b0.at_target), 32'h1);

      // ---- angle sweep ----
      for (int v = 0; v < 16; v++) begin
         logic ovl;
         ovl = 1'b0;
         cmd0(tbl[v].ang, 1'b0);
         for (int k = 0; k < 16; k++) begin
            tick();
            if (b0.valves_l != 2'b00 && b0.valves_r != 2'b00) ovl = 1'b1;
         end
         chk("sweep_l", 32'(b0.valves_l), 32'(tbl[v].l));
         chk("sweep_r", 32'(b0.valves_r), 32'(tbl[v].r));
         chk("sweep_busy", 32'(b0.busy), 32'h0);
         chk("sweep_overlap", 32'(ovl), 32'h0);
      end

      // ---- ang without ang_valid is ignored ----
      b0.ang = -4'sd8;
      ticks(8);
      chk("novalid_r", 32'(b0.valves_r), 32'h3);
      chk("novalid_busy", 32'(b0.busy), 32'h0);

      // ---- side crossing: -2 -> +1 ----
      cmd0(-4'sd8, 1'b0);
      ticks(16);
      chk("cross_start_l", 32'(b0.valves_l), 32'h3);
      cmd0(4'sd2, 1'b0);                            // edge E
      chk("cross_l_e0", 32'(b0.valves_l), 32'h3);
      for (int e = 1; e <= 12; e++) begin
         tick();
         chk("cross_l", 32'(b0.valves_l), (e < 5) ? 32'h1 : 32'h0);
         chk("cross_r", 32'(b0.valves_r), (e < 9) ? 32'h0 : 32'h1);
      end

      // ---- retarget with center priority ----
      cmd0(4'sd0, 1'b0);
      ticks(8);
      chk("rt_start_r", 32'(b0.valves_r), 32'h0);
      cmd0(4'sd7, 1'b0);                            // edge E
      tick();                                       // E+1: first step
      chk("rt_r_e1", 32'(b0.valves_r), 32'h1);
      cmd0(-4'sd1, 1'b1);                           // E+2: center wins
      chk("rt_busy_e2", 32'(b0.busy), 32'h1);
      chk("rt_r_e2", 32'(b0.valves_r), 32'h1);
      ticks(2);                                     // E+4
      chk("rt_r_e4", 32'(b0.valves_r), 32'h1);
      tick();                                       // E+5: back to neutral
      chk("rt_r_e5", 32'(b0.valves_r), 32'h0);
      chk("rt_l_e5", 32'(b0.valves_l), 32'h0);
      chk("rt_busy_e5", 32'(b0.busy), 32'h0);
      ticks(8);
      chk("rt_l_hold", 32'(b0.valves_l), 32'h0);
      chk("rt_at_target", 32'(b0.at_target), 32'h1);

      // ---- reset mid-move ----
      cmd0(-4'sd8, 1'b0);
      ticks(2);                                     // pos=-1, dwelling
      chk("rmid_l_before", 32'(b0.valves_l), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rmid_l", 32'(b0.valves_l), 32'h0);
      chk("rmid_r", 32'(b0.valves_r), 32'h0);
      chk("rmid_busy", 32'(b0.busy), 32'h0);
      ticks(8);
      chk("rmid_l_hold", 32'(b0.valves_l), 32'h0);
      chk("rmid_at_target", 32'(b0.at_target), 32'h1);

      // ---- STEP_CYC=1: one stage per edge ----
      b1.ang = -4'sd8; b1.ang_valid = 1'b1;
      tick();
      b1.ang_valid = 1'b0;
      ticks(2);
      chk("fast_start_l", 32'(b1.valves_l), 32'h3);
      b1.ang = 4'sd7; b1.ang_valid = 1'b1;
      tick();                                       // edge E
      b1.ang_valid = 1'b0;
      tick(); chk("fast_l_e1", 32'(b1.valves_l), 32'h1);
      tick(); chk("fast_l_e2", 32'(b1.valves_l), 32'h0);
              chk("fast_r_e2", 32'(b1.valves_r), 32'h0);
      tick(); chk("fast_r_e3", 32'(b1.valves_r), 32'h1);
      tick(); chk("fast_r_e4", 32'(b1.valves_r), 32'h3);
              chk("fast_busy_e4", 32'(b1.busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
